// File: rtl/mem_port_arbiter.sv
// Two-port arbiter sharing one line-granular DataMemory between the I-cache (port 0)
// and the D-cache (port 1): one whole-line transaction in flight at a time.
module mem_port_arbiter #(
  parameter int LINE_SIZE  = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic                    req0_valid,
  input  logic [ADDR_WIDTH-1:0]   req0_addr,
  input  logic                    req0_read,
  input  logic                    req0_write,
  input  logic [LINE_SIZE*8-1:0]  req0_din,
  output logic                    req0_ready,

  input  logic                    req1_valid,
  input  logic [ADDR_WIDTH-1:0]   req1_addr,
  input  logic                    req1_read,
  input  logic                    req1_write,
  input  logic [LINE_SIZE*8-1:0]  req1_din,
  output logic                    req1_ready,

  output logic                    resp0_valid,
  output logic                    resp1_valid,
  output logic [LINE_SIZE*8-1:0]  resp_dout,

  output logic                    mem_is_input_valid,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic                    mem_read,
  output logic                    mem_write,
  output logic [LINE_SIZE*8-1:0]  mem_din,
  input  logic                    mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0]  mem_dout,
  input  logic                    mem_ready
);

  localparam int LINE_BITS   = LINE_SIZE * 8;
  localparam int OFFSET_BITS = $clog2(LINE_SIZE);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_RD, WAIT_WR, RESP} state_t;
  typedef enum logic [1:0] {OP_NONE, OP_READ, OP_WRITE} op_t;

  state_t                 state_q, state_d;
  logic                   rr_ptr_q;
  logic                   grant_q;
  op_t                    op_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [LINE_BITS-1:0]   din_q;
  logic [LINE_BITS-1:0]   resp_dout_q;

  logic                   sel;
  logic                   take;
  logic                   load_dout;
  logic [ADDR_WIDTH-1:0]  sel_addr;
  logic [LINE_BITS-1:0]   sel_din;
  op_t                    sel_op;

  // Round-robin pointer only breaks ties; a lone requester always wins.
  always_comb begin
    sel      = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;
    sel_addr = sel ? req1_addr : req0_addr;
    sel_din  = sel ? req1_din  : req0_din;
    if (sel ? req1_write : req0_write)
      sel_op = OP_WRITE;
    else if (sel ? req1_read : req0_read)
      sel_op = OP_READ;
    else
      sel_op = OP_NONE;
  end

  always_comb begin
    state_d            = state_q;
    take               = 1'b0;
    load_dout          = 1'b0;
    req0_ready         = 1'b0;
    req1_ready         = 1'b0;
    resp0_valid        = 1'b0;
    resp1_valid        = 1'b0;
    mem_is_input_valid = 1'b0;
    mem_addr           = '0;
    mem_read           = 1'b0;
    mem_write          = 1'b0;
    mem_din            = '0;

    case (state_q)
      IDLE: begin
        // Gated by reset so the acknowledge stays low while reset is held.
        if (reset && (req0_valid || req1_valid)) begin
          take       = 1'b1;
          req0_ready = ~sel;
          req1_ready = sel;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (op_q == OP_NONE) begin
          state_d = RESP;
        end else begin
          mem_is_input_valid = 1'b1;
          mem_read           = (op_q == OP_READ);
          mem_write          = (op_q == OP_WRITE);
          mem_addr           = addr_q >> OFFSET_BITS;
          mem_din            = din_q;
          if (mem_ready)
            state_d = (op_q == OP_READ) ? WAIT_RD : WAIT_WR;
        end
      end
      WAIT_RD: begin
        if (mem_is_output_valid) begin
          load_dout = 1'b1;
          state_d   = RESP;
        end
      end
      WAIT_WR: begin
        if (mem_ready)
          state_d = RESP;
      end
      RESP: begin
        resp0_valid = ~grant_q;
        resp1_valid = grant_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rr_ptr_q    <= 1'b1;
      grant_q     <= 1'b0;
      op_q        <= OP_NONE;
      addr_q      <= '0;
      din_q       <= '0;
      resp_dout_q <= '0;
    end else begin
      state_q <= state_d;
      if (take) begin
        grant_q <= sel;
        op_q    <= sel_op;
        addr_q  <= sel_addr;
        din_q   <= sel_din;
      end
      if (load_dout)
        resp_dout_q <= mem_dout;
      else if (state_q == RESP)
        resp_dout_q <= '0;
      if (state_q == RESP)
        rr_ptr_q <= ~grant_q;
    end
  end

  assign resp_dout = resp_dout_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requests push expected grants,
// memory operations and responses; monitors and a DataMemory model pop and compare.
module tb_mem_port_arbiter;

  localparam int AW  = 32;
  localparam int LB  = 128;
  localparam int LAT = 2;

  localparam logic [LB-1:0] L10 = 128'h1010_0001_1010_0002_1010_0003_1010_0004;
  localparam logic [LB-1:0] L20 = 128'h2020_0001_2020_0002_2020_0003_2020_0004;
  localparam logic [LB-1:0] L11 = 128'h1111_AAAA_1111_BBBB_1111_CCCC_1111_DDDD;
  localparam logic [LB-1:0] L21 = 128'h2121_AAAA_2121_BBBB_2121_CCCC_2121_DDDD;
  localparam logic [LB-1:0] L14 = 128'h0BAD_F00D_CAFE_BABE_1234_5678_DEAD_BEEF;
  localparam logic [LB-1:0] L30 = 128'h3030_3030_5A5A_5A5A_A5A5_A5A5_0303_0303;
  localparam logic [LB-1:0] L50 = 128'h5050_5050_5050_5050_5050_5050_5050_5050;
  localparam logic [LB-1:0] WB  = 128'h11223344_55667788_99AABBCC_DDEEFF00;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           req0_valid = 1'b0, req0_read = 1'b0, req0_write = 1'b0;
  logic [AW-1:0]  req0_addr = '0;
  logic [LB-1:0]  req0_din = '0;
  logic           req1_valid = 1'b0, req1_read = 1'b0, req1_write = 1'b0;
  logic [AW-1:0]  req1_addr = '0;
  logic [LB-1:0]  req1_din = '0;
  logic           req0_ready, req1_ready, resp0_valid, resp1_valid;
  logic [LB-1:0]  resp_dout;
  logic           mem_is_input_valid, mem_read, mem_write;
  logic [AW-1:0]  mem_addr;
  logic [LB-1:0]  mem_din;
  logic           mem_is_output_valid = 1'b0;
  logic [LB-1:0]  mem_dout = '0;
  logic           mem_ready = 1'b1;

  mem_port_arbiter #(.LINE_SIZE(16), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_read(req0_read),
    .req0_write(req0_write), .req0_din(req0_din), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_read(req1_read),
    .req1_write(req1_write), .req1_din(req1_din), .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_dout(resp_dout),
    .mem_is_input_valid(mem_is_input_valid), .mem_addr(mem_addr),
    .mem_read(mem_read), .mem_write(mem_write), .mem_din(mem_din),
    .mem_is_output_valid(mem_is_output_valid), .mem_dout(mem_dout),
    .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { bit port; logic [LB-1:0] data; } resp_t;
  typedef struct { logic [AW-1:0] addr; bit wr; logic [LB-1:0] din; } memop_t;
  resp_t  exp_resp[$];
  bit     exp_grant[$];
  memop_t exp_mem[$];

  task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_txn(input bit p, input logic [AW-1:0] line, input bit use_mem,
                            input bit wr, input logic [LB-1:0] din, input logic [LB-1:0] rdata);
    resp_t  r;
    memop_t m;
    exp_grant.push_back(p);
    if (use_mem) begin
      m.addr = line; m.wr = wr; m.din = din;
      exp_mem.push_back(m);
    end
    r.port = p; r.data = rdata;
    exp_resp.push_back(r);
  endtask

  // DataMemory model: one request at a time, LAT cycles busy after acceptance.
  logic [LB-1:0] mem_img [logic [AW-1:0]];
  int  busy = 0, stall = 0, low_seen = 0, iv_cyc = 0, accepts = 0;
  bit  pending = 0, was_read = 0, unstable = 0, have_prev = 0;
  logic [AW-1:0] cur_addr;
  logic [AW+LB+1:0] prev_out;

  initial begin
    memop_t m;
    forever begin
      @(negedge clk);
      if (!reset) begin
        mem_ready = 1'b1; mem_is_output_valid = 1'b0; mem_dout = '0;
        pending = 0; busy = 0; have_prev = 0;
        continue;
      end
      mem_is_output_valid = 1'b0;
      mem_dout = '0;
      if (pending) begin
        mem_ready = 1'b0; busy = LAT; pending = 0;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          mem_ready = 1'b1;
          if (was_read) begin
            mem_is_output_valid = 1'b1;
            mem_dout = mem_img.exists(cur_addr) ? mem_img[cur_addr] : '0;
          end
        end
      end else if (stall > 0) begin
        mem_ready = 1'b0;
        if (mem_is_input_valid) begin stall--; low_seen++; end
      end else begin
        mem_ready = 1'b1;
      end
      if (mem_is_input_valid) begin
        iv_cyc++;
        if (have_prev && {mem_addr, mem_read, mem_write, mem_din} !== prev_out) unstable = 1;
        prev_out  = {mem_addr, mem_read, mem_write, mem_din};
        have_prev = 1;
      end else begin
        have_prev = 0;
      end
      if (mem_is_input_valid && mem_ready) begin
        pending = 1; accepts++; have_prev = 0;
        was_read = mem_read; cur_addr = mem_addr;
        if (mem_write) mem_img[mem_addr] = mem_din;
        if (exp_mem.size() == 0) begin
          total++; bad++;
          $display("FAIL mem_unexpected: got access to %0h expected none", mem_addr);
        end else begin
          m = exp_mem.pop_front();
          check("mem_addr", mem_addr, m.addr);
          check("mem_op", {mem_read, mem_write}, m.wr ? 2'b01 : 2'b10);
          if (m.wr) check("mem_din", mem_din, m.din);
        end
      end
    end
  end

  int last_ready_cyc = 0, last_resp_cyc = 0, resp_cnt = 0;

  // Monitor: samples mid low phase, well away from the rising edge.
  initial begin
    bit    g;
    resp_t r;
    forever begin
      @(negedge clk);
      #2;
      if (!reset) continue;
      if (req0_ready || req1_ready) begin
        check("ready_onehot", req0_ready & req1_ready, 1'b0);
        last_ready_cyc = cyc;
        if (exp_grant.size() == 0) begin
          total++; bad++;
          $display("FAIL grant_unexpected: got ready %0d%0d expected none", req1_ready, req0_ready);
        end else begin
          g = exp_grant.pop_front();
          check("grant_port", req1_ready, g);
        end
      end
      if (resp0_valid || resp1_valid) begin
        check("resp_onehot", resp0_valid & resp1_valid, 1'b0);
        last_resp_cyc = cyc;
        resp_cnt++;
        if (exp_resp.size() == 0) begin
          total++; bad++;
          $display("FAIL resp_unexpected: got resp %0d%0d expected none", resp1_valid, resp0_valid);
        end else begin
          r = exp_resp.pop_front();
          check("resp_port", resp1_valid, r.port);
          check("resp_data", resp_dout, r.data);
        end
      end
    end
  end

  // Caller sits at a negedge; returns at the negedge after the accepting edge.
  task automatic req(input bit p, input logic [AW-1:0] a, input bit rd, input bit wr,
                     input logic [LB-1:0] d);
    bit got = 0;
    if (p) begin req1_valid = 1; req1_addr = a; req1_read = rd; req1_write = wr; req1_din = d; end
    else   begin req0_valid = 1; req0_addr = a; req0_read = rd; req0_write = wr; req0_din = d; end
    for (int n = 0; n < 200 && !got; n++) begin
      #1;
      if (p ? req1_ready : req0_ready) got = 1;
      else @(negedge clk);
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL req_timeout: port %0d got no ready expected ready", p);
    end
    @(negedge clk);
    // Scramble the fields to show the in-flight transaction ignores them.
    if (p) begin req1_valid = 0; req1_addr = '1; req1_read = 1; req1_write = 0; req1_din = '1; end
    else   begin req0_valid = 0; req0_addr = '1; req0_read = 1; req0_write = 0; req0_din = '1; end
  endtask

  task automatic drain();
    for (int n = 0; n < 300 && exp_resp.size() != 0; n++) @(negedge clk);
    check("drain_resp", exp_resp.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    int iv0, low0, acc0, rc0;
    mem_img[32'h10] = L10; mem_img[32'h20] = L20;
    mem_img[32'h11] = L11; mem_img[32'h21] = L21;
    mem_img[32'h14] = L14; mem_img[32'h30] = L30;
    mem_img[32'h50] = L50;

    repeat (2) @(negedge clk);
    #2;
    check("rst_ctrl", {req0_ready, req1_ready, resp0_valid, resp1_valid,
                       mem_is_input_valid, mem_read, mem_write}, '0);
    check("rst_dout", resp_dout, '0);
    check("rst_maddr", mem_addr, '0);
    check("rst_mdin", mem_din, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Tie from reset: port 1 first, then strict alternation while both hold requests.
    expect_txn(1, 32'h10, 1, 0, '0, L10);
    expect_txn(0, 32'h20, 1, 0, '0, L20);
    expect_txn(1, 32'h11, 1, 0, '0, L11);
    expect_txn(0, 32'h21, 1, 0, '0, L21);
    fork
      begin req(1, 32'h100, 1, 0, '0); req(1, 32'h110, 1, 0, '0); end
      begin req(0, 32'h200, 1, 0, '0); req(0, 32'h210, 1, 0, '0); end
    join
    drain();

    expect_txn(1, 32'h14, 1, 0, '0, L14);
    req(1, 32'h140, 1, 0, '0);
    drain();
    check("rd_latency", last_resp_cyc - last_ready_cyc, LAT + 3);

    // Write-back with read also set: write must win.
    expect_txn(1, 32'h23, 1, 1, WB, '0);
    req(1, 32'h230, 1, 1, WB);
    drain();
    expect_txn(0, 32'h23, 1, 0, '0, WB);
    req(0, 32'h234, 1, 0, '0);
    drain();

    stall = 5;
    @(negedge clk);
    iv0 = iv_cyc; low0 = low_seen;
    expect_txn(0, 32'h30, 1, 0, '0, L30);
    req(0, 32'h300, 1, 0, '0);
    drain();
    check("stall_low_cycles", low_seen - low0, 5);
    check("stall_issue_cycles", iv_cyc - iv0, 6);
    check("stall_stable", unstable, 1'b0);

    iv0 = iv_cyc;
    expect_txn(0, 32'h0, 0, 0, '0, '0);
    req(0, 32'h400, 0, 0, WB);
    drain();
    check("noop_latency", last_resp_cyc - last_ready_cyc, 2);
    check("noop_no_mem", iv_cyc - iv0, 0);

    // Abort a read while the memory is busy.
    acc0 = accepts;
    exp_grant.push_back(1'b0);
    begin
      memop_t m;
      m.addr = 32'h50; m.wr = 0; m.din = '0;
      exp_mem.push_back(m);
    end
    req(0, 32'h500, 1, 0, '0);
    for (int n = 0; n < 50; n++) begin
      if (accepts != acc0) break;
      @(negedge clk);
      #1;
    end
    check("abort_accepted", accepts - acc0, 1);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("abort_ctrl", {req0_ready, req1_ready, resp0_valid, resp1_valid,
                         mem_is_input_valid, mem_read, mem_write}, '0);
    check("abort_dout", resp_dout, '0);
    check("abort_maddr", mem_addr, '0);
    rc0 = resp_cnt;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("abort_no_resp", resp_cnt - rc0, 0);

    expect_txn(1, 32'h14, 1, 0, '0, L14);
    req(1, 32'h140, 1, 0, '0);
    drain();
    check("end_grants", exp_grant.size(), 0);
    check("end_mem", exp_mem.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no completion expected finish");
    $fatal(1);
  end

endmodule
